// File: rtl/oled_sched_pkg.sv
// oled_sched_pkg: shared state encoding, task indices and colour constants for the OLED task scheduler
package oled_sched_pkg;

    typedef enum logic [1:0] {
        ST_MENU  = 2'd0,
        ST_BLANK = 2'd1,
        ST_RUN   = 2'd2
    } state_e;

    localparam logic [1:0] TASK_A = 2'd0;
    localparam logic [1:0] TASK_B = 2'd1;
    localparam logic [1:0] TASK_C = 2'd2;
    localparam logic [1:0] TASK_D = 2'd3;

    localparam logic [15:0] BLACK = 16'h0000;

    localparam logic [15:0] MENU_COLOUR [4] = '{16'hF800, 16'h07E0, 16'h001F, 16'hFD60};

endpackage

// File: rtl/oled_task_scheduler_btn_debounce.sv
// btn_debounce: synchronised rising-edge detector with a per-button lockout window
//   clock   in  system clock
//   reset   in  synchronous active-high reset
//   btn_i   in  raw button level
//   press_o out one-cycle pulse per accepted press
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 10_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_i,
    output logic press_o
);

    localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    // sync_q[1:0] is the two-flop synchroniser, sync_q[2] the previous synchronised level
    logic [2:0]    sync_q;
    logic [CW-1:0] cnt_q, cnt_d;

    assign press_o = sync_q[1] & ~sync_q[2] & (cnt_q == '0);

    always_comb begin
        cnt_d = press_o ? CW'(DEBOUNCE_CYCLES - 1) : (cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= '0;
            cnt_q  <= '0;
        end else begin
            sync_q <= {sync_q[1:0], btn_i};
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/oled_task_scheduler.sv
// oled_task_scheduler: arbitrates the OLED between four task blocks with a menu and blank-frame task switches
//   clock, reset                 system clock, synchronous active-high reset
//   btnC/btnU/btnL/btnR/btnD     raw buttons
//   frame_begin                  start-of-frame pulse from the OLED driver
//   pixel_data_A..D              RGB565 from each task block
//   task_running                 one-hot task enables (bit0 = A)
//   btnC_task, btnU_task         gated press pulses to the running task
//   pixel_data                   registered RGB565 to the OLED driver
//   sel_led                      one-hot menu selection
module oled_task_scheduler
    import oled_sched_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 10_000_000,
    parameter int unsigned BLANK_FRAMES    = 2,
    parameter int unsigned NUM_TASKS       = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 btnC,
    input  logic                 btnU,
    input  logic                 btnL,
    input  logic                 btnR,
    input  logic                 btnD,
    input  logic                 frame_begin,
    input  logic [15:0]          pixel_data_A,
    input  logic [15:0]          pixel_data_B,
    input  logic [15:0]          pixel_data_C,
    input  logic [15:0]          pixel_data_D,
    output logic [NUM_TASKS-1:0] task_running,
    output logic                 btnC_task,
    output logic                 btnU_task,
    output logic [15:0]          pixel_data,
    output logic [3:0]           sel_led
);

    logic   press_c, press_u, press_l, press_r, press_d;
    state_e state_q, state_d;
    logic [1:0]  sel_q, sel_d, target_q, target_d;
    logic        ret_menu_q, ret_menu_d;
    logic [3:0]  fcnt_q, fcnt_d;
    logic [15:0] pix_d, task_pix;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_c (.clock(clock), .reset(reset), .btn_i(btnC), .press_o(press_c));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_u (.clock(clock), .reset(reset), .btn_i(btnU), .press_o(press_u));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_l (.clock(clock), .reset(reset), .btn_i(btnL), .press_o(press_l));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_r (.clock(clock), .reset(reset), .btn_i(btnR), .press_o(press_r));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_d (.clock(clock), .reset(reset), .btn_i(btnD), .press_o(press_d));

    assign sel_led  = 4'b0001 << sel_q;
    assign task_pix = (target_q == TASK_A) ? pixel_data_A :
                      (target_q == TASK_B) ? pixel_data_B :
                      (target_q == TASK_C) ? pixel_data_C : pixel_data_D;

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        target_d     = target_q;
        ret_menu_d   = ret_menu_q;
        fcnt_d       = fcnt_q;
        task_running = '0;
        btnC_task    = 1'b0;
        btnU_task    = 1'b0;
        pix_d        = BLACK;
        case (state_q)
            ST_MENU: begin
                pix_d = MENU_COLOUR[sel_q];
                // launch takes priority over navigation in the same cycle
                if (press_c) begin
                    target_d   = sel_q;
                    ret_menu_d = 1'b0;
                    fcnt_d     = '0;
                    state_d    = ST_BLANK;
                end else if (press_l & ~press_r) begin
                    sel_d = sel_q - 2'd1;
                end else if (press_r & ~press_l) begin
                    sel_d = sel_q + 2'd1;
                end
            end
            ST_BLANK: begin
                if (frame_begin) begin
                    if (fcnt_q == 4'(BLANK_FRAMES - 1))
                        state_d = ret_menu_q ? ST_MENU : ST_RUN;
                    else
                        fcnt_d = fcnt_q + 4'd1;
                end
            end
            ST_RUN: begin
                task_running = NUM_TASKS'(4'b0001 << target_q);
                pix_d        = task_pix;
                // an exit press suppresses anything forwarded in the same cycle
                btnC_task    = press_c & ~press_d;
                btnU_task    = press_u & ~press_d;
                if (press_d) begin
                    ret_menu_d = 1'b1;
                    fcnt_d     = '0;
                    state_d    = ST_BLANK;
                end
            end
            default: state_d = ST_MENU;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_MENU;
            sel_q      <= '0;
            target_q   <= '0;
            ret_menu_q <= 1'b0;
            fcnt_q     <= '0;
            pixel_data <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            target_q   <= target_d;
            ret_menu_q <= ret_menu_d;
            fcnt_q     <= fcnt_d;
            pixel_data <= pix_d;
        end
    end

endmodule
